// File: rtl/gated_xor_pipe_if.sv
// Valid/ready bundle for gated_xor_pipe: operand beat in, result beat out, activity counter.
// master = surrounding environment, slave = the pipe itself.
interface gated_xor_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             act_clr;
   logic [CNT_W-1:0] act_cnt;

   modport master (
      output in_valid, en, a, b, c, mode, out_ready, act_clr,
      input  in_ready, out_valid, y, act_cnt
   );

   modport slave (
      input  in_valid, en, a, b, c, mode, out_ready, act_clr,
      output in_ready, out_valid, y, act_cnt
   );
endinterface

// File: rtl/gated_xor_pipe.sv
// gated_xor_pipe: per-lane gated (a&c)|(a^b) behind a STAGES-deep valid/ready pipeline.
// The output activity counter is built only when GATED_XOR_PIPE_ACTIVITY_EN is defined.
module gated_xor_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   gated_xor_pipe_if.slave    bus
);

   logic [STAGES-1:0] r_vld;
   logic [WIDTH-1:0]  r_dat [STAGES];
   logic              r_rdy_en;
   logic [STAGES-1:0] w_move;
   logic              w_full;
   logic              w_in_ready;
   logic              w_acc;
   logic              w_deliver;
   logic [WIDTH-1:0]  w_func;

   // Lane function, selected by the mode bit that travels with the beat.
   always_comb begin
      w_func = '0;
      if (bus.mode) begin
         w_func = ~bus.en & ((bus.a & bus.c) | (bus.a ^ bus.b));
      end else begin
         w_func = bus.en & ((bus.a & bus.c) | (bus.a ^ bus.b));
      end
   end

   // A stage may move when downstream takes the output or any stage from here on holds a bubble.
   always_comb begin
      w_full = 1'b1;
      w_move = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         w_full    = w_full & r_vld[s];
         w_move[s] = bus.out_ready | ~w_full;
      end
   end

   assign w_in_ready = r_rdy_en & w_move[0];
   assign w_acc      = bus.in_valid & w_in_ready;
   assign w_deliver  = r_vld[STAGES-1] & bus.out_ready;

   // Ready stays low through reset and comes up on the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   // Pipeline stages: data registers load only when a valid beat actually enters them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_dat[s] <= '0;
         end
      end else begin
         if (w_move[0]) begin
            r_vld[0] <= w_acc;
            if (w_acc) begin
               r_dat[0] <= w_func;
            end
         end
         for (int s = 1; s < STAGES; s++) begin
            if (w_move[s]) begin
               r_vld[s] <= r_vld[s-1];
               if (r_vld[s-1]) begin
                  r_dat[s] <= r_dat[s-1];
               end
            end
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_vld[STAGES-1];
   assign bus.y         = r_dat[STAGES-1];

`ifdef GATED_XOR_PIPE_ACTIVITY_EN
   localparam int SUM_W = CNT_W + 8;

   function automatic logic [7:0] popcount(input logic [WIDTH-1:0] v);
      logic [7:0] n;
      n = 8'd0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + {7'd0, v[i]};
      end
      return n;
   endfunction

   logic [WIDTH-1:0] r_prev_y;
   logic [CNT_W-1:0] r_act_cnt;
   logic [SUM_W-1:0] w_sum;

   // Widened sum so saturation can be detected without wrap.
   always_comb begin
      w_sum = SUM_W'(r_act_cnt) + SUM_W'(popcount(r_dat[STAGES-1] ^ r_prev_y));
   end

   // Toggle accounting on delivered beats; clear wins over a same-cycle delivery.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_y  <= '0;
         r_act_cnt <= '0;
      end else if (bus.act_clr) begin
         r_prev_y  <= '0;
         r_act_cnt <= '0;
      end else if (w_deliver) begin
         r_prev_y  <= r_dat[STAGES-1];
         r_act_cnt <= (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
      end
   end

   assign bus.act_cnt = r_act_cnt;
`else
   assign bus.act_cnt = '0;
`endif

endmodule

// File: doc/gated_xor_pipe.md
GATED_XOR_PIPE -- requirements
Module: gated_xor_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: lane count, 1..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth, 1..4.
REQ-003 SHALL have parameter CNT_W, default 16: activity-counter width, 4..32.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all flops on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts the beat this cycle.
REQ-008 SHALL have port en, input, WIDTH bits: per-lane enable.
REQ-009 SHALL have ports a, b, c, input, WIDTH bits each: per-lane operands.
REQ-010 SHALL have port mode, input, 1 bit, sampled with the beat: 0 = base function, 1 = inverted-gate function.
REQ-011 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-013 SHALL have port y, output, WIDTH bits: result.
REQ-014 SHALL have port act_clr, input, 1 bit: synchronous clear of the activity counter.
REQ-015 SHALL have port act_cnt, output, CNT_W bits: output toggle count.

Function
REQ-016 SHALL compute per lane i in mode 0: y[i] = en[i] & ((a[i] & c[i]) | (a[i] ^ b[i])).
REQ-017 SHALL compute per lane i in mode 1: y[i] = ~en[i] & ((a[i] & c[i]) | (a[i] ^ b[i])).
REQ-018 SHALL accept a beat when in_valid & in_ready; SHALL deliver it when out_valid & out_ready.
REQ-019 SHALL produce a result on y/out_valid exactly STAGES cycles after acceptance when there is no stall.
REQ-020 SHALL drive in_ready = out_ready | ~(stage-1 valid) | (some later stage holds a bubble), so bubbles collapse.
REQ-021 SHALL hold y and out_valid stable while out_valid & ~out_ready; SHALL NOT drop or duplicate beats.
REQ-022 SHALL sustain one beat per cycle with out_ready held high.
REQ-023 SHALL NOT load a stage's data register unless that stage advances (operand isolation, power); stage data otherwise holds.
REQ-024 SHALL keep all beats in order; only the valid bit SHALL be cleared on bubbles, never the data.

Reset
REQ-025 SHALL, on rst_n low (asynchronous), clear all stage valids, y, and act_cnt to 0.
REQ-026 SHALL hold in_ready = 0 while rst_n is low and assert it on the first clock after release.
REQ-027 SHALL discard beats in flight on reset mid-operation; no residual out_valid after release.

Configuration
REQ-028 SHALL compile the activity counter only when macro GATED_XOR_PIPE_ACTIVITY_EN is defined.
REQ-029 SHALL, with the macro defined, on each delivered beat, add popcount(y ^ previous delivered y) to act_cnt, saturating at all-ones.
REQ-030 SHALL, with the macro defined, give act_clr priority over a same-cycle increment; previous y resets to 0.
REQ-031 SHALL, without the macro, tie act_cnt to 0 and ignore act_clr; the port list SHALL be unchanged.

Verification
REQ-032 SHALL verify truth table: WIDTH=8, mode=0, en=FF, a=F0, b=CC, c=AA -> y=3C|A0=BC after exactly 2 cycles.
REQ-033 SHALL verify mode 1: en=0F, a=FF, b=00, c=00, mode=1 -> y=F0; same operands with mode=0 -> y=0F.
REQ-034 SHALL verify backpressure: 6 back-to-back beats, out_ready low for cycles 3..7 -> all 6 beats delivered in order, none lost, in_ready low once the pipe is full.
REQ-035 SHALL verify reset mid-stream: rst_n pulsed low with 2 beats in flight -> out_valid=0, act_cnt=0 immediately; first beat after release appears 2 cycles after acceptance.
REQ-036 SHALL verify the activity counter (macro defined), CNT_W=4: delivered y sequence 00, FF, 00 -> act_cnt=0, 8, 15 (saturated); act_clr -> 0.
REQ-037 SHALL verify the build without the macro: the same y sequence -> act_cnt stays 0.
